// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   DEPTH         - default queue entry count (power of two, 2..8)
//   RESET_PC      - default first fetch address after reset
//   fetch_entry_t - one queued instruction: {pc, inst}
//   fetch_state_t - fetch FSM states: REQ (may issue) / WAIT (response pending)
package fetch_pkg;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    REQ,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding prefetched instructions.
//   clk, rst   - clock, asynchronous active-low reset
//   flush      - synchronous clear; wins over push and pop in the same cycle
//   push       - write push_data at the tail (caller guarantees room)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry, valid whenever count != 0
//   count      - occupancy, 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = fetch_pkg::DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_pkg::fetch_entry_t      push_data,
  input  logic                         pop,
  output fetch_pkg::fetch_entry_t      head,
  output logic [$clog2(DEPTH):0]       count
);
  import fetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count guards every read, so its contents never matter while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch unit: issues one word-aligned read at a time and
// queues {pc, inst} pairs for the datapath.
//   clk, rst                 - clock, asynchronous active-low reset
//   mem_req/addr/gnt         - request channel; addr held until granted
//   mem_rvalid/rdata         - response channel, honoured only in WAIT
//   inst_valid/inst/inst_pc  - queue head toward the datapath
//   inst_ready               - datapath consumes the head
//   redirect/redirect_pc     - taken control transfer; flushes and reloads pc
//   count                    - queue occupancy
module inst_fetch_queue #(
  parameter int          DEPTH    = fetch_pkg::DEPTH,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] count
);
  import fetch_pkg::*;

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             squash_q, squash_d;
  logic             push, pop;
  fetch_entry_t     push_data, head;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_pc_bits;

  // Only one request is ever in flight and every earlier response is
  // already counted, so "count < DEPTH" at issue reserves the slot.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    squash_d   = squash_q;
    mem_req    = 1'b0;
    push       = 1'b0;
    case (state_q)
      REQ: begin
        // rst gating keeps the request low while reset is held.
        mem_req = rst & (fifo_count < FULL_CNT) & ~redirect;
        if (mem_req && mem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          // A response coinciding with a redirect is stale as well.
          push     = ~squash_q & ~redirect;
          squash_d = 1'b0;
          state_d  = REQ;
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect) fetch_pc_d = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      squash_q   <= squash_d;
    end
  end

  assign push_data = '{pc: req_pc_q, inst: mem_rdata};
  // Redirect flushes the queue, so a same-cycle handshake is not a consume.
  assign pop       = inst_valid & inst_ready & ~redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign mem_addr   = fetch_pc_q;
  assign inst_valid = (fifo_count != '0);
  assign inst       = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;
  assign count      = fifo_count;

  assign unused_pc_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: memory responder, scoreboard of
// expected {pc, inst} pairs, and directed scenarios for redirect/reset/wrap.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Scoreboard: expected {pc, inst} in fetch order.
  logic [63:0] exp_q[$];
  task automatic push_expected(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      logic [31:0] pc;
      pc = base + 32'(4 * k);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  // Memory responder state.
  bit          gnt_rand      = 1'b0;
  bit          gnt_block     = 1'b0;
  int          rsp_delay_cfg = 0;
  bit          rsp_pend      = 1'b0;
  int          rsp_delay     = 0;
  logic [31:0] rsp_addr      = '0;
  bit          hold          = 1'b0;
  logic [31:0] hold_addr     = '0;
  int          gnt_delay     = 0;
  logic [31:0] issued_q[$];
  int          grant_cnt     = 0;
  int          consumed      = 0;

  initial begin : responder
    forever begin
      @(negedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (rsp_pend) begin
        if (rsp_delay == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(rsp_addr);
          rsp_pend   = 1'b0;
        end else begin
          rsp_delay--;
        end
      end
      if (mem_req) begin
        if (hold) check("addr_hold", mem_addr, hold_addr);
        else begin
          hold      = 1'b1;
          hold_addr = mem_addr;
          gnt_delay = gnt_rand ? int'($urandom_range(0, 5)) : 0;
        end
        mem_gnt = !gnt_block && (gnt_delay == 0);
        if (gnt_delay > 0) gnt_delay--;
      end else begin
        hold    = 1'b0;
        mem_gnt = gnt_block ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      #2;
      if (rst && mem_req && mem_gnt) begin
        issued_q.push_back(mem_addr);
        grant_cnt++;
        rsp_pend  = 1'b1;
        rsp_delay = rsp_delay_cfg;
        rsp_addr  = mem_addr;
        hold      = 1'b0;
      end
    end
  end

  initial begin : consumer_monitor
    forever begin
      @(negedge clk);
      #3;
      if (rst && inst_valid && inst_ready && !redirect) begin
        if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e[63:32]);
          check("inst", inst, e[31:0]);
          consumed++;
        end
      end
    end
  end

  task automatic wait_grant(input int max_cycles);
    int start;
    start = grant_cnt;
    for (int i = 0; i < max_cycles && grant_cnt == start; i++) @(negedge clk);
    check("grant_seen", 32'(grant_cnt != start), 32'd1);
  endtask

  task automatic check_issued(input string tag, input int idx, input logic [31:0] a0,
                              input logic [31:0] a1);
    check({tag, "_n"}, 32'(issued_q.size() >= idx + 2), 32'd1);
    if (issued_q.size() >= idx + 2) begin
      check({tag, "_a0"}, issued_q[idx], a0);
      check({tag, "_a1"}, issued_q[idx+1], a1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int idx;
    rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // Fill with gnt tied high, rvalid one cycle after grant.
    push_expected(32'h0, 200);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("req_after_reset", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'd0);
    for (int i = 0; i < 60 && count != 3'd4; i++) @(negedge clk);
    check("fill_count", 32'(count), 32'd4);
    check("fill_issued_n", 32'(issued_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < issued_q.size(); k++) check("fill_addr", issued_q[k], 32'(4 * k));
    check("req_drop_full", 32'(mem_req), 32'd0);
    repeat (3) @(negedge clk);
    check("req_stay_low", 32'(mem_req), 32'd0);
    check("count_hold", 32'(count), 32'd4);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #2;
    check("req_resume", 32'(mem_req), 32'd1);
    check("resume_addr", mem_addr, 32'd16);
    check("count_after_pop", 32'(count), 32'd3);

    // Random grant delays and random consumption.
    gnt_rand = 1'b1;
    repeat (200) begin
      @(negedge clk);
      inst_ready = ($urandom_range(0, 2) != 0);
    end
    inst_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("consumed_random", 32'(consumed > 20), 32'd1);

    // Redirect while waiting for a slow response.
    gnt_rand = 1'b0;
    rsp_delay_cfg = 2;
    wait_grant(20);
    idx = issued_q.size();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    push_expected(32'h0000_0100, 16);
    @(negedge clk);
    redirect = 1'b0; redirect_pc = '0;
    check("redir_aligned_addr", mem_addr, 32'h0000_0100);
    repeat (20) @(negedge clk);
    check_issued("redir_wait", idx, 32'h0000_0100, 32'h0000_0104);

    // Redirect coincident with rvalid and a datapath handshake.
    rsp_delay_cfg = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && count == 3'd0; i++) @(negedge clk);
    wait_grant(20);
    check("pre_valid", 32'(inst_valid), 32'd1);
    idx = issued_q.size();
    redirect = 1'b1; redirect_pc = 32'h0000_0100; inst_ready = 1'b1;
    push_expected(32'h0000_0100, 16);
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(inst_valid), 32'd0);
    redirect = 1'b0; redirect_pc = '0;
    repeat (12) @(negedge clk);
    check_issued("redir_rvalid", idx, 32'h0000_0100, 32'h0000_0104);

    // Address wrap at the top of memory.
    idx = issued_q.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_expected(32'hFFFF_FFFC, 16);
    #2;
    check("redirect_withdraw", 32'(mem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0; redirect_pc = '0;
    repeat (12) @(negedge clk);
    check_issued("wrap", idx, 32'hFFFF_FFFC, 32'h0000_0000);

    // Reset pulse while a response is outstanding.
    inst_ready = 1'b0;
    rsp_delay_cfg = 2;
    wait_grant(20);
    rst = 1'b0;
    gnt_block = 1'b1;
    #1;
    check("async_mem_req", 32'(mem_req), 32'd0);
    check("async_inst_valid", 32'(inst_valid), 32'd0);
    check("async_inst", inst, 32'd0);
    check("async_inst_pc", inst_pc, 32'd0);
    check("async_mem_addr", mem_addr, 32'd0);
    check("async_count", 32'(count), 32'd0);
    push_expected(32'h0, 16);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("stale_count", 32'(count), 32'd0);
    check("stale_valid", 32'(inst_valid), 32'd0);
    gnt_block = 1'b0;
    rsp_delay_cfg = 0;
    inst_ready = 1'b1;
    idx = issued_q.size();
    repeat (12) @(negedge clk);
    check_issued("after_reset", idx, 32'h0000_0000, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
